uart_tx_arbiter: RTL and testbench

//  Shares one uart_transmit instance (DATA_WIDTH-bit frames) between N_REQ producers.
//  - Accepts one word at a time from a requester using valid/ready.
//  - Picks the requester by round-robin.
//  - Drives the transmitter's trigger/data pins and tracks its busy line until the frame is done.
//  - Sits between the frame producers and the single TX wire.

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_transmit between N_REQ producers:
// accepts a word, launches it, tracks tx busy, then enforces an idle gap.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int DATA_WIDTH   = 11,
   parameter int BUSY_TIMEOUT = 16,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic [N_REQ-1:0]              req_valid_in,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_data_in,
   output logic [N_REQ-1:0]              req_ready_out,
   input  logic                          tx_busy_in,
   output logic                          tx_trigger_out,
   output logic [DATA_WIDTH-1:0]         tx_data_out,
   output logic [$clog2(N_REQ)-1:0]      grant_id_out,
   output logic                          active_out,
   output logic                          timeout_err_out,
   output logic [2:0]                    state_out
);

   localparam int IDW     = $clog2(N_REQ);
   localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GAP       = 3'd4
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;
   logic [IDW-1:0]        r_last, w_winner, r_grant_id;
   logic                  w_found, w_grant, w_timeout;
   logic [1:0]            r_rst_sync;
   logic                  w_rst_n;
   logic                  r_trigger;
   logic [DATA_WIDTH-1:0] r_data;

   // Reset asserts asynchronously and releases two clocks after rst_n_in rises.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_rst_sync <= 2'b00;
      else           r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   // Rotating priority: search starts just after the last winner.
   always_comb begin
      int v_idx;
      w_found  = 1'b0;
      w_winner = '0;
      v_idx    = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         v_idx = (int'(r_last) + k) % N_REQ;
         if (!w_found && req_valid_in[v_idx]) begin
            w_found  = 1'b1;
            w_winner = IDW'(v_idx);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_grant     = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // tx_busy_in guard covers a transmitter still busy after reset.
            if (w_found && !tx_busy_in) begin
               w_grant     = 1'b1;
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy_in) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_WAIT_DONE: begin
            w_cnt_nxt = '0;
            if (!tx_busy_in) w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (r_cnt == CW'(GAP_CYCLES - 1)) w_state_nxt = S_IDLE;
            else                              w_cnt_nxt   = r_cnt + CW'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_last     <= IDW'(N_REQ - 1);
         r_trigger  <= 1'b0;
         r_data     <= '0;
         r_grant_id <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_trigger <= w_grant;
         if (w_grant) begin
            r_data     <= req_data_in[w_winner*DATA_WIDTH +: DATA_WIDTH];
            r_grant_id <= w_winner;
            r_last     <= w_winner;
         end
      end
   end

   // Handshake: a word transfers in the cycle where req_valid_in[i] & req_ready_out[i];
   // ready is offered only in IDLE, one-hot to the winner, while the transmitter is idle.
   assign req_ready_out   = w_grant ? (N_REQ'(1) << w_winner) : '0;
   assign tx_trigger_out  = r_trigger;
   assign tx_data_out     = r_data;
   assign grant_id_out    = r_grant_id;
   assign active_out      = (r_state != S_IDLE);
   assign timeout_err_out = w_timeout;
   assign state_out       = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: busy-stub transmitter models, table-driven grants,
// scoreboard of {grant,data} checked on every trigger, plus multi-cycle corner sequences.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 11;
  localparam int IW = 2;

  typedef struct {
    logic [N-1:0]  mask;
    logic [IW-1:0] grant;
    logic [DW-1:0] data;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic [N-1:0]    valid = '0, valid0 = '0;
  logic [N*DW-1:0] data = '0, data0 = '0;
  logic [N-1:0]    ready, ready0;
  logic            busy = 1'b0, busy0 = 1'b0;
  logic            trig, trig0, act, act0, tout, tout0;
  logic [DW-1:0]   txd, txd0;
  logic [IW-1:0]   gid, gid0;
  logic [2:0]      st, st0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(16), .GAP_CYCLES(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(valid), .req_data_in(data),
    .req_ready_out(ready), .tx_busy_in(busy), .tx_trigger_out(trig), .tx_data_out(txd),
    .grant_id_out(gid), .active_out(act), .timeout_err_out(tout), .state_out(st));

  uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(16), .GAP_CYCLES(0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(valid0), .req_data_in(data0),
    .req_ready_out(ready0), .tx_busy_in(busy0), .tx_trigger_out(trig0), .tx_data_out(txd0),
    .grant_id_out(gid0), .active_out(act0), .timeout_err_out(tout0), .state_out(st0));

  int total = 0;
  int bad   = 0;
  logic [IW+DW-1:0] exp_q[$];
  logic [IW+DW-1:0] exp0_q[$];
  logic [IW+DW-1:0] mon_e, mon_e0;

  // transmitter stubs: busy rises rise_dly cycles after trigger, stays high frame_len cycles
  int rise_cnt = 0, len_cnt = 0, rise_dly = 2, frame_len = 8;
  int rise_cnt0 = 0, len_cnt0 = 0, rise_dly0 = 1, frame_len0 = 4;
  bit never_rise = 1'b0, force_busy = 1'b0;

  always @(negedge clk) begin
    if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) len_cnt = frame_len;
    end else if (len_cnt > 0) len_cnt--;
    if (trig && !never_rise) rise_cnt = rise_dly;
    busy = force_busy || (len_cnt > 0);
  end

  always @(negedge clk) begin
    if (rise_cnt0 > 0) begin
      rise_cnt0--;
      if (rise_cnt0 == 0) len_cnt0 = frame_len0;
    end else if (len_cnt0 > 0) len_cnt0--;
    if (trig0) rise_cnt0 = rise_dly0;
    busy0 = (len_cnt0 > 0);
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // scoreboard monitors: every launched frame must match the oldest expected entry
  always @(negedge clk) begin
    if (trig) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_extra: actual=grant%0d required=none", gid);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_data", 32'(txd), 32'(mon_e[DW-1:0]));
        check("sb_grant", 32'(gid), 32'(mon_e[IW+DW-1:DW]));
      end
    end
  end

  always @(negedge clk) begin
    if (trig0) begin
      if (exp0_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb0_extra: actual=grant%0d required=none", gid0);
      end else begin
        mon_e0 = exp0_q.pop_front();
        check("sb0_data", 32'(txd0), 32'(mon_e0[DW-1:0]));
        check("sb0_grant", 32'(gid0), 32'(mon_e0[IW+DW-1:DW]));
      end
    end
  end

  function automatic logic [N*DW-1:0] words(input logic [IW-1:0] w, input logic [DW-1:0] d);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      r[i*DW +: DW] = (i == int'(w)) ? d : (~d ^ DW'(i + 1));
    return r;
  endfunction

  // all wait tasks are entered and left at negedge+1
  task automatic wait_idle(input bit sel);
    bit ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (sel ? (!act0 && !busy0) : (!act && !busy)) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) fail_bound("wait_idle");
  endtask

  task automatic wait_ready(input bit sel, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if ((sel ? ready0 : ready) != '0) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) fail_bound("wait_ready");
  endtask

  task automatic wait_busy(input bit sel, input logic level);
    bit ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if ((sel ? busy0 : busy) == level) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) fail_bound("wait_busy");
  endtask

  task automatic send(input bit sel, input logic [N-1:0] mask, input logic [IW-1:0] g,
                      input logic [DW-1:0] d);
    wait_idle(sel);
    if (sel) begin data0 = words(g, d); valid0 = mask; exp0_q.push_back({g, d}); end
    else     begin data  = words(g, d); valid  = mask; exp_q.push_back({g, d});  end
    #1;
    check("ready_onehot", 32'(sel ? ready0 : ready), 32'(4'b0001 << g));
    @(negedge clk);
    check("trig_latency", 32'(sel ? trig0 : trig), 32'd1);
    check("ready_launch", 32'(sel ? ready0 : ready), 32'd0);
    if (sel) valid0 = '0; else valid = '0;
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_trig"},  32'(trig),  32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_data"},  32'(txd),   32'd0);
    check({tag, "_gid"},   32'(gid),   32'd0);
    check({tag, "_act"},   32'(act),   32'd0);
    check({tag, "_tout"},  32'(tout),  32'd0);
    check({tag, "_state"}, 32'(st),    32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    bit              ok;
    logic [N*DW-1:0] w;
    logic [IW-1:0]   g;
    logic [N-1:0]    mask;
    int              first, pulses, hits, m_last;
    bit              fnd;
    int              curw[N], maxw[N];

    // grants follow from last=2 after the single-request frame
    vecs[0]  = '{4'b1111, 2'd3, 11'h0F1};
    vecs[1]  = '{4'b1111, 2'd0, 11'h7FE};
    vecs[2]  = '{4'b1001, 2'd3, 11'h001};
    vecs[3]  = '{4'b1001, 2'd0, 11'h3C3};
    vecs[4]  = '{4'b0110, 2'd1, 11'h2AA};
    vecs[5]  = '{4'b0010, 2'd1, 11'h155};
    vecs[6]  = '{4'b1010, 2'd3, 11'h400};
    vecs[7]  = '{4'b0001, 2'd0, 11'h0E7};
    vecs[8]  = '{4'b0011, 2'd1, 11'h612};
    vecs[9]  = '{4'b1100, 2'd2, 11'h09C};
    vecs[10] = '{4'b0101, 2'd0, 11'h5D0};

    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;

    // continuous requests from all four: strict rotation 0,1,2,3,0
    w = words(2'd0, 11'h2C7);
    data = w;
    for (int f = 0; f < 5; f++) begin
      g = IW'(f % N);
      exp_q.push_back({g, w[g*DW +: DW]});
    end
    valid = 4'b1111;
    #1;
    for (int f = 0; f < 5; f++) begin
      g = IW'(f % N);
      wait_ready(1'b0, ok);
      if (ok) check("rr_continuous", 32'(ready), 32'(4'b0001 << g));
      @(negedge clk); #1;
    end
    valid = '0;

    // single request on requester 2; active spans busy fall plus two gap cycles
    send(1'b0, 4'b0100, 2'd2, 11'h5A3);
    wait_busy(1'b0, 1'b1);
    wait_busy(1'b0, 1'b0);
    check("act_busy_fall", 32'(act), 32'd1);
    @(negedge clk); #1;
    check("act_gap1", 32'(act), 32'd1);
    @(negedge clk); #1;
    check("act_gap2", 32'(act), 32'd1);
    @(negedge clk); #1;
    check("act_idle", 32'(act), 32'd0);
    check("hold_data", 32'(txd), 32'h5A3);
    check("hold_gid", 32'(gid), 32'd2);

    for (int i = 0; i < 11; i++)
      send(1'b0, vecs[i].mask, vecs[i].grant, vecs[i].data);

    // busy never rises: abort 16 cycles after the trigger cycle, rotation moves on
    never_rise = 1'b1;
    send(1'b0, 4'b1111, 2'd1, 11'h3A5);
    first = 0;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (tout) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 17) check("timeout_to_idle", 32'(act), 32'd0);
    end
    check("timeout_cycle", 32'(first), 32'd16);
    check("timeout_pulses", 32'(pulses), 32'd1);
    never_rise = 1'b0;
    send(1'b0, 4'b1111, 2'd2, 11'h1B4);

    // reset while the transmitter is mid-frame
    send(1'b0, 4'b0001, 2'd0, 11'h6E1);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (st == 3'd3) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) fail_bound("reach_wait_done");
    force_busy = 1'b1;
    rst_n = 1'b0;
    #1;
    check_zero("midframe_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    w = words(2'd0, 11'h0AB);
    data = w;
    valid = 4'b1111;
    exp_q.push_back({2'd0, 11'h0AB});
    hits = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (ready != '0) hits++;
    end
    check("busy_guard", 32'(hits), 32'd0);
    force_busy = 1'b0;
    @(negedge clk); #1;
    wait_busy(1'b0, 1'b0);
    check("post_rst_first", 32'(ready), 32'd1);
    @(negedge clk);
    valid = '0;
    #1;

    // GAP_CYCLES=0: ready returns on the first cycle after busy falls
    wait_idle(1'b1);
    data0 = words(2'd1, 11'h777);
    valid0 = 4'b0010;
    exp0_q.push_back({2'd1, 11'h777});
    exp0_q.push_back({2'd1, 11'h777});
    #1;
    wait_ready(1'b1, ok);
    if (ok) check("gap0_first", 32'(ready0), 32'd2);
    @(negedge clk); #1;
    wait_busy(1'b1, 1'b1);
    wait_busy(1'b1, 1'b0);
    check("gap0_busy_fall", 32'(ready0), 32'd0);
    @(negedge clk); #1;
    check("gap0_next_ready", 32'(ready0), 32'd2);
    @(negedge clk);
    valid0 = '0;
    #1;

    // 100 random request masks: rotation and bounded waiting
    m_last = 1;
    for (int i = 0; i < N; i++) begin curw[i] = 0; maxw[i] = 0; end
    for (int f = 0; f < 100; f++) begin
      mask = N'($urandom_range(1, 15));
      fnd = 1'b0;
      g = '0;
      for (int k = 1; k <= N; k++) begin
        if (!fnd && mask[(m_last + k) % N]) begin
          fnd = 1'b1;
          g = IW'((m_last + k) % N);
        end
      end
      send(1'b1, mask, g, DW'($urandom_range(0, 2047)));
      m_last = int'(g);
      for (int i = 0; i < N; i++) begin
        if (mask[i] && i != int'(g)) curw[i]++;
        else curw[i] = 0;
        if (curw[i] > maxw[i]) maxw[i] = curw[i];
      end
    end
    for (int i = 0; i < N; i++)
      check("starvation", 32'(maxw[i] > N - 1), 32'd0);

    wait_idle(1'b0);
    wait_idle(1'b1);
    repeat (3) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    check("sb0_drain", 32'(exp0_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
